fir_stream_master: RTL and testbench

AHB-Lite master that feeds the memory-mapped FIR filter slave from a valid/ready sample stream and returns filtered results on a valid/ready result stream. For each accepted sample it writes the SAMPLE register, waits a fixed settle time, polls STATUS until the filter is idle, then reads RESULT. It sits directly upstream of `ahb_lite_fir_filter` on the same AHB-Lite bus. It replaces bench-driven transactions in the system build.

---
 rtl/fir_stream_pkg.sv | 26 ++
 rtl/flex_counter.sv | 26 ++
 rtl/fir_stream_master.sv | 130 +++++++++++++
 tb/tb_fir_stream_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared types and constants for the FIR stream master
package fir_stream_pkg;

    typedef enum logic [3:0] {
        REG_STATUS = 4'h0,
        REG_RESULT = 4'h2,
        REG_SAMPLE = 4'h4
    } reg_addr_t;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [3:0] {
        S_IDLE, S_ACPT, S_WR_A, S_WR_D, S_SETTLE,
        S_POLL_A, S_POLL_D, S_RD_A, S_RD_D, S_OUT
    } state_t;

    localparam int          STATUS_BUSY_BIT = 0;
    localparam int          STATUS_ERR_BIT  = 8;
    localparam logic [2:0]  HSIZE_HALF      = 3'b001;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to zero when it reaches rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    assign rollover_flag = count_enable && (count_out + NUM_CNT_BITS'(1) == rollover_val);

    // count up while enabled, wrapping on the increment that reaches rollover_val
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= rollover_flag ? '0 : count_out + NUM_CNT_BITS'(1);
    end

endmodule

// File: rtl/fir_stream_master.sv
// fir_stream_master: AHB-Lite master feeding the FIR slave from a sample stream (option: FIR_STREAM_STATUS_ERR_EN)
module fir_stream_master
    import fir_stream_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH_BITS = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int POLL_LIMIT      = 16
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [DATA_WIDTH_BITS-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [DATA_WIDTH_BITS-1:0] result_out,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       err,
    input  logic                       clear_err,
    output logic                       hsel,
    output logic [1:0]                 htrans,
    output logic [ADDR_WIDTH-1:0]      haddr,
    output logic [2:0]                 hsize,
    output logic                       hwrite,
    output logic [DATA_WIDTH_BITS-1:0] hwdata,
    input  logic [DATA_WIDTH_BITS-1:0] hrdata,
    input  logic                       hresp
);

    localparam int CNT_MAX = (SETTLE_CYCLES > POLL_LIMIT) ? SETTLE_CYCLES : POLL_LIMIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                     r_state;
    state_t                     w_next;
    htrans_t                    r_htrans;
    logic                       r_sample_ready, r_result_valid, r_err, r_hsel, r_hwrite;
    logic [ADDR_WIDTH-1:0]      r_haddr;
    logic [2:0]                 r_hsize;
    logic [DATA_WIDTH_BITS-1:0] r_sample, r_hwdata, r_result;
    logic [CNT_W-1:0]           w_cnt;
    logic                       w_cnt_flag, w_cnt_en, w_busy, w_stat_err, w_err_evt, w_addr_ph;

    // the settle count wraps to zero on its final cycle, so polling starts from a fresh count
    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (r_state == S_ACPT),
        .count_enable (w_cnt_en),
        .rollover_val (CNT_W'(r_state == S_SETTLE ? SETTLE_CYCLES : POLL_LIMIT)),
        .count_out    (w_cnt),
        .rollover_flag(w_cnt_flag)
    );

    assign w_cnt_en = (r_state == S_SETTLE) || (r_state == S_POLL_D);
    assign w_busy   = hrdata[STATUS_BUSY_BIT];
`ifdef FIR_STREAM_STATUS_ERR_EN
    assign w_stat_err = hrdata[STATUS_ERR_BIT];
`else
    assign w_stat_err = 1'b0;
`endif
    assign w_err_evt = (hresp && (r_state inside {S_WR_D, S_POLL_D, S_RD_D}))
                    || (r_state == S_POLL_D && (w_stat_err || (w_busy && w_cnt == CNT_W'(POLL_LIMIT - 1))));
    assign w_addr_ph = w_next inside {S_WR_A, S_POLL_A, S_RD_A};

    // next-state decode; any error event drops back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = sample_valid ? S_ACPT : S_IDLE;
            S_ACPT:   w_next = S_WR_A;
            S_WR_A:   w_next = S_WR_D;
            S_WR_D:   w_next = hresp ? S_IDLE : S_SETTLE;
            S_SETTLE: w_next = w_cnt_flag ? S_POLL_A : S_SETTLE;
            S_POLL_A: w_next = S_POLL_D;
            S_POLL_D: w_next = w_err_evt ? S_IDLE : w_busy ? S_POLL_A : S_RD_A;
            S_RD_A:   w_next = S_RD_D;
            S_RD_D:   w_next = hresp ? S_IDLE : S_OUT;
            S_OUT:    w_next = result_ready ? S_IDLE : S_OUT;
            default:  w_next = S_IDLE;
        endcase
    end

    // state plus every output registered from the next state so they change only on the edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= S_IDLE;
            r_sample_ready <= 1'b1;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_sample       <= '0;
            r_result       <= '0;
            r_hsel         <= 1'b0;
            r_htrans       <= HT_IDLE;
            r_haddr        <= '0;
            r_hsize        <= '0;
            r_hwrite       <= 1'b0;
            r_hwdata       <= '0;
        end else begin
            r_state        <= w_next;
            r_sample_ready <= (w_next == S_IDLE);
            r_result_valid <= (w_next == S_OUT);
            r_err          <= w_err_evt || (r_err && !clear_err);
            r_hsel         <= w_addr_ph;
            r_htrans       <= w_addr_ph ? HT_NONSEQ : HT_IDLE;
            if (r_state == S_IDLE && sample_valid)
                r_sample <= sample_in;
            if (w_addr_ph) begin
                r_haddr  <= ADDR_WIDTH'(w_next == S_WR_A ? REG_SAMPLE : w_next == S_POLL_A ? REG_STATUS : REG_RESULT);
                r_hwrite <= (w_next == S_WR_A);
                r_hsize  <= HSIZE_HALF;
            end
            if (w_next == S_WR_D)
                r_hwdata <= r_sample;
            if (r_state == S_RD_D && !hresp)
                r_result <= hrdata;
        end
    end

    assign sample_ready = r_sample_ready;
    assign result_valid = r_result_valid;
    assign result_out   = r_result;
    assign err          = r_err;
    assign hsel         = r_hsel;
    assign htrans       = r_htrans;
    assign haddr        = r_haddr;
    assign hsize        = r_hsize;
    assign hwrite       = r_hwrite;
    assign hwdata       = r_hwdata;

endmodule

// File: tb/tb_fir_stream_master.sv
// tb_fir_stream_master: directed bench with a zero-wait FIR slave model (honours FIR_STREAM_STATUS_ERR_EN)
module tb_fir_stream_master;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] result_out;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        err;
    logic        clear_err = 1'b0;
    logic        hsel;
    logic [1:0]  htrans;
    logic [3:0]  haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    always #5 clk = ~clk;

    fir_stream_master dut (
        .clk(clk), .n_rst(n_rst),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .result_out(result_out), .result_valid(result_valid), .result_ready(result_ready),
        .err(err), .clear_err(clear_err),
        .hsel(hsel), .htrans(htrans), .haddr(haddr), .hsize(hsize), .hwrite(hwrite),
        .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp)
    );

    // slave model: FIR with coefficients 0.5, 1, 1, 0.5 and a programmable number of busy polls
    logic        d_act = 1'b0, d_wr = 1'b0;
    logic [3:0]  d_addr = '0, last_wr_addr = '0;
    logic [2:0]  last_wr_size = '0;
    logic [15:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, last_wr_data = '0, fir_res;
    logic        resp_wr = 1'b0, stat_err = 1'b0, clr_stats = 1'b0, rv_seen = 1'b0;
    int          busy_cfg = 0, busy_left = 0, st_reads = 0, rd_reads = 0, wr_cnt = 0, viol = 0;
    int          n_chk = 0, n_pass = 0, n;

    assign fir_res = (x0 >> 1) + x1 + x2 + (x3 >> 1);
    assign hrdata  = !d_act ? 16'h0 :
                     d_addr == 4'h0 ? {7'b0, stat_err, 7'b0, busy_left > 0} :
                     d_addr == 4'h2 ? fir_res : 16'h0;
    assign hresp   = d_act && d_wr && resp_wr;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_act <= 1'b0;
        end else begin
            if (clr_stats) begin
                busy_left <= busy_cfg;
                st_reads  <= 0;
                rd_reads  <= 0;
                wr_cnt    <= 0;
                rv_seen   <= 1'b0;
            end else begin
                if (result_valid) rv_seen <= 1'b1;
                if (d_act) begin
                    if (hsel || htrans != 2'b00) viol <= viol + 1;
                    if (d_wr && !resp_wr) begin
                        wr_cnt <= wr_cnt + 1;
                        last_wr_data <= hwdata;
                        x0 <= hwdata; x1 <= x0; x2 <= x1; x3 <= x2;
                    end
                    if (!d_wr && d_addr == 4'h0) begin
                        st_reads <= st_reads + 1;
                        if (busy_left > 0) busy_left <= busy_left - 1;
                    end
                    if (!d_wr && d_addr == 4'h2) rd_reads <= rd_reads + 1;
                end
            end
            d_act <= hsel && htrans == 2'b10;
            if (hsel && htrans == 2'b10) begin
                d_addr <= haddr;
                d_wr   <= hwrite;
                if (hwrite) begin
                    last_wr_addr <= haddr;
                    last_wr_size <= hsize;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr(input int busy);
        busy_cfg = busy;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        check("ready_before_send", sample_ready, 1);
        sample_in = v;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_rv(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 80) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!sample_ready && cyc < 80) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_hsel", hsel, 0);
        check("rst_htrans", htrans, 0);
        check("rst_haddr", haddr, 0);
        check("rst_hsize", hsize, 0);
        check("rst_hwrite", hwrite, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_result_out", result_out, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_err", err, 0);
        check("rst_sample_ready", sample_ready, 1);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // first sample: 100 -> 0.5*100 = 50
        clr(0);
        send(16'd100);
        wait_rv(n);
        check("latency", n, 9);
        check("s1_valid", result_valid, 1);
        check("s1_result", result_out, 50);
        check("s1_wr_addr", last_wr_addr, 4'h4);
        check("s1_wr_data", last_wr_data, 100);
        check("s1_wr_size", last_wr_size, 3'b001);
        check("s1_status_reads", st_reads, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", result_valid, 1);
            check("hold_result", result_out, 50);
            check("hold_sample_ready", sample_ready, 0);
        end
        release_result();
        check("rel_sample_ready", sample_ready, 1);
        check("rel_result_valid", result_valid, 0);

        // second sample: 200 -> 0.5*200 + 100 = 200
        clr(0);
        send(16'd200);
        wait_rv(n);
        check("s2_valid", result_valid, 1);
        check("s2_result", result_out, 200);
        release_result();

        // busy for 20 polls: timeout after exactly 16
        clr(20);
        send(16'd7);
        wait_idle(n);
        check("to_idle", sample_ready, 1);
        check("to_status_reads", st_reads, 16);
        check("to_result_reads", rd_reads, 0);
        check("to_err", err, 1);
        check("to_no_result", rv_seen, 0);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check("clear_err", err, 0);

        // error response on the SAMPLE write data phase
        clr(0);
        resp_wr = 1'b1;
        send(16'd9);
        wait_idle(n);
        resp_wr = 1'b0;
        check("hr_idle", sample_ready, 1);
        check("hr_err", err, 1);
        check("hr_status_reads", st_reads, 0);
        check("hr_no_result", rv_seen, 0);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check("hr_clear", err, 0);

        // STATUS reports error bit but not busy
        clr(0);
        stat_err = 1'b1;
        send(16'd11);
        n = 0;
        while (!result_valid && !sample_ready && n < 80) begin @(posedge clk); #1; n++; end
`ifdef FIR_STREAM_STATUS_ERR_EN
        check("se_err", err, 1);
        check("se_result_reads", rd_reads, 0);
        check("se_no_result", result_valid, 0);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
`else
        check("se_valid", result_valid, 1);
        check("se_result_reads", rd_reads, 1);
        check("se_err", err, 0);
        release_result();
`endif
        stat_err = 1'b0;

        // reset in the middle of a transfer
        clr(0);
        send(16'd5);
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("mr_hsel", hsel, 0);
        check("mr_htrans", htrans, 0);
        check("mr_haddr", haddr, 0);
        check("mr_hwrite", hwrite, 0);
        check("mr_sample_ready", sample_ready, 1);
        n_rst = 1'b1;
        @(posedge clk); #1;

        check("no_pipelined_data_phase", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
